// File: rtl/issue_rat_redeem_queue_pkg.sv
// Shared issue-stage constants and the redeem-queue entry layout.
// Kept in one package so rename, free list and redeem queue agree on widths.
package issue_rat_redeem_queue_pkg;

    localparam int PRF_W = 6;
    localparam int FGR_W = 4;

    typedef logic [PRF_W-1:0] prf_t;

    typedef struct packed {
        prf_t prf;
        logic nodest;
    } rat_entry_t;

endpackage

// File: rtl/issue_rat_redeem_queue.sv
// Holds previous PRF mappings from rename until retire, then drains them in
// order to the free list. Flush discards only entries that have not retired.
module issue_rat_redeem_queue
    import issue_rat_redeem_queue_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PRF_W-1:0]         i_enq_prf,
    input  logic                     i_enq_nodest,
    input  logic                     i_enq_valid,
    output logic                     o_enq_ready,
    input  logic                     i_retire_valid,
    input  logic                     i_flush_valid,
    output logic [PRF_W-1:0]         o_redeemed_prf,
    output logic                     o_redeemed_valid,
    input  logic                     i_redeemed_ready,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    typedef logic [PW-1:0] ptr_t;

    ptr_t       wr_ptr, ret_ptr, rd_ptr;
    ptr_t       wr_next, ret_next, rd_next;
    ptr_t       count;
    rat_entry_t mem [DEPTH];
    rat_entry_t head;
    logic       full;
    logic       enq_fire;
    logic       retire_fire;
    logic       drain_pending;
    logic       deq_fire;

    // Wrap bit in the MSB lets plain subtraction give occupancy across wrap.
    assign count         = wr_ptr - rd_ptr;
    assign full          = (count == ptr_t'(DEPTH));
    assign enq_fire      = i_enq_valid && o_enq_ready;
    assign retire_fire   = i_retire_valid && (ret_ptr != wr_ptr);
    assign drain_pending = (rd_ptr != ret_ptr);
    assign head          = mem[rd_ptr[IW-1:0]];
    // Entries without a PRF are skipped in one cycle without a handshake.
    assign deq_fire      = drain_pending && (head.nodest || i_redeemed_ready);

    always_comb begin
        ret_next = ret_ptr + ptr_t'(retire_fire);
        rd_next  = rd_ptr + ptr_t'(deq_fire);
        wr_next  = i_flush_valid ? ret_next : wr_ptr + ptr_t'(enq_fire);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            ret_ptr <= '0;
            rd_ptr  <= '0;
        end else begin
            wr_ptr  <= wr_next;
            ret_ptr <= ret_next;
            rd_ptr  <= rd_next;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read after
    // it has been written, so clearing the array would buy nothing.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wr_ptr[IW-1:0]] <= '{prf: i_enq_prf, nodest: i_enq_nodest};
        end
    end

    assign o_enq_ready      = !full && !i_flush_valid;
    assign o_redeemed_valid = drain_pending && !head.nodest;
    assign o_redeemed_prf   = o_redeemed_valid ? head.prf : '0;
    assign o_count          = count;

endmodule
